ip_rom_arbiter: RTL
===================

// Module: ip_rom_arbiter
// PURPOSE
//  Shares one synchronous IP ROM (14-bit address, 8-bit data, n_cs/n_rd strobes, 1-cycle rdata_en) between two requesters.
//  Port A is the Z80 bus side and has high priority. Port B is a secondary reader (boot copier/debug) and has low priority.
//  Sequences each ROM access, routes the returned byte to the owning port, and prevents B starvation and hung reads.
//  Sits between the cartridge bus decoder/loader and the ROM instance.
// PARAMETERS
//  STARVE_LIMIT  8  consecutive cycles B may wait with req high before it wins one arbitration over A (1..255)
//  TIMEOUT       4  cycles WAIT tolerates without rom_rdata_en before forcing completion (1..15)
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous, active-high reset
//  a_req          in   1   A read request; level, held until a_ack
//  a_address      in   14  A address; stable while a_req=1
//  a_ack          out  1   1-cycle pulse: A request accepted
//  a_rdata        out  8   A read data; valid when a_rdata_en=1, else 0
//  a_rdata_en     out  1   1-cycle pulse: a_rdata valid
//  b_req, b_address, b_ack, b_rdata, b_rdata_en    as A, for port B
//  rom_n_cs       out  1   ROM chip select, active low
//  rom_n_rd       out  1   ROM read strobe, active low
//  rom_address    out  14  ROM address
//  rom_rdata      in   8   ROM data
//  rom_rdata_en   in   1   ROM data valid
//  timeout        out  1   1-cycle pulse with rdata_en when a read was force-completed
// BEHAVIOUR
//  - All outputs registered. Reset values: rom_n_cs=1, rom_n_rd=1, rom_address=0, all ack/rdata_en/timeout=0, rdata=0.
//    Also on reset: state=IDLE, starve counter=0, wait counter=0.
//  - FSM IDLE -> ISSUE -> WAIT -> IDLE.
//    - IDLE: if any req, choose owner, latch address/owner, pulse owner ack, go ISSUE.
//    - ISSUE: rom_n_cs=0, rom_n_rd=0 for exactly one cycle, rom_address=latched; go WAIT.
//    - WAIT: on rom_rdata_en=1, register rom_rdata to owner rdata, pulse owner rdata_en; go IDLE.
//      If the wait counter reaches TIMEOUT first: owner rdata=8'hFF, rdata_en=1, timeout=1; go IDLE.
//  - Latency: req seen in IDLE at cycle N -> ack at N+1, ROM strobe at N+1, ROM data at N+2, owner rdata_en at N+3.
//    One access per 3 cycles max; requester may hold req after rdata_en for back-to-back reads.
//  - Arbitration:
//    - A wins when both request, unless starve counter >= STARVE_LIMIT, then B wins and the counter clears.
//    - Starve counter increments (saturating at 255) each cycle b_req=1 and B not granted.
//    - Clears when B granted or b_req=0.
//  - A requester must not drop req between ack and rdata_en; dropping req after ack does not cancel the access.
//  - Non-owner rdata/rdata_en stay 0. rom_rdata_en outside WAIT is ignored.
//  - rom_n_cs/rom_n_rd are never low outside ISSUE, and never low for two consecutive cycles.
//  - Reset mid-access: abandon immediately and return to IDLE; no rdata_en is emitted for the aborted access.
//  - Address is latched at grant; a_address/b_address changes after ack have no effect.
// STRUCTURE
//  - Single module, no sub-module. FSM state codes and TIMEOUT_DATA=8'hFF are localparams.
//  - The ROM bus width constants (14/8) belong in the shared cartridge-bus include used by all ip_*_rom blocks.
// TESTING
//  1. Reset: hold reset 3 cycles -> rom_n_cs=rom_n_rd=1, all ack/rdata_en=0; release with no req -> stays idle.
//  2. A alone: a_req=1, a_address=0 (ROM byte F3) -> a_ack at +1, rom strobe at +1, a_rdata=F3 with a_rdata_en at +3.
//     b outputs stay 0.
//  3. B alone: b_address=31 -> b_rdata=01 at +3; back-to-back b_address=46 -> 81 three cycles later.
//  4. Contention: a_req and b_req both held continuously, STARVE_LIMIT=8 -> A served repeatedly.
//     B granted once b has waited >=8 cycles, then A resumes; no lost or duplicated rdata_en.
//  5. Timeout: ROM model suppresses rom_rdata_en -> owner rdata=FF, rdata_en=1, timeout=1 exactly TIMEOUT cycles after ISSUE.
//  6. Reset asserted in WAIT -> no rdata_en follows; next request after release completes normally with correct data.

Source files
------------

// File: rtl/ip_rom_arbiter_pkg.sv
// Shared definitions for the IP ROM arbiter: ROM bus widths, FSM and owner encodings.
package ip_rom_arbiter_pkg;

  // ROM bus geometry shared by all ip_*_rom blocks on the cartridge bus
  localparam int unsigned ROM_AW = 14;
  localparam int unsigned ROM_DW = 8;

  // Byte returned to the owner when a read is force-completed
  localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Which requester owns the access in flight
  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

endpackage

// File: rtl/ip_rom_arbiter.sv
// Two-port arbiter in front of a synchronous IP ROM.
// Port A (Z80 bus) has priority; port B gets one grant after waiting STARVE_LIMIT
// cycles. Each access runs IDLE -> ISSUE -> WAIT; a WAIT that sees no rom_rdata_en
// for TIMEOUT cycles is force-completed with TIMEOUT_DATA and a timeout pulse.
module ip_rom_arbiter
  import ip_rom_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned TIMEOUT      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic [ROM_AW-1:0] a_address,
  output logic              a_ack,
  output logic [ROM_DW-1:0] a_rdata,
  output logic              a_rdata_en,
  input  logic              b_req,
  input  logic [ROM_AW-1:0] b_address,
  output logic              b_ack,
  output logic [ROM_DW-1:0] b_rdata,
  output logic              b_rdata_en,
  output logic              rom_n_cs,
  output logic              rom_n_rd,
  output logic [ROM_AW-1:0] rom_address,
  input  logic [ROM_DW-1:0] rom_rdata,
  input  logic              rom_rdata_en,
  output logic              timeout
);

  localparam logic [7:0] STARVE_LIMIT_C = 8'(STARVE_LIMIT);
  // Last WAIT count tolerated before the read is forced to complete
  localparam logic [3:0] WAIT_LAST_C    = 4'(TIMEOUT - 1);

  state_t              state_r, state_s;
  owner_t              owner_r, owner_s;
  logic [ROM_AW-1:0]   addr_r, addr_s;
  logic [7:0]          starve_r, starve_s;
  logic [3:0]          wait_r, wait_s;
  logic                grant_b_s;
  logic                a_ack_s, b_ack_s;
  logic [ROM_DW-1:0]   a_rdata_s, b_rdata_s;
  logic                a_rdata_en_s, b_rdata_en_s;
  logic                rom_n_cs_s, rom_n_rd_s;
  logic [ROM_AW-1:0]   rom_address_s;
  logic                timeout_s;

  // Next-state, arbitration and next-output computation for the access sequencer
  always_comb begin
    state_s       = state_r;
    owner_s       = owner_r;
    addr_s        = addr_r;
    wait_s        = wait_r;
    grant_b_s     = 1'b0;
    a_ack_s       = 1'b0;
    b_ack_s       = 1'b0;
    a_rdata_s     = 8'h00;
    b_rdata_s     = 8'h00;
    a_rdata_en_s  = 1'b0;
    b_rdata_en_s  = 1'b0;
    rom_n_cs_s    = 1'b1;
    rom_n_rd_s    = 1'b1;
    rom_address_s = rom_address;
    timeout_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (a_req || b_req) begin
          // B wins only when alone or when it has been starved long enough
          grant_b_s     = b_req && (!a_req || (starve_r >= STARVE_LIMIT_C));
          owner_s       = grant_b_s ? OWN_B : OWN_A;
          addr_s        = grant_b_s ? b_address : a_address;
          a_ack_s       = !grant_b_s;
          b_ack_s       = grant_b_s;
          // Strobe is registered now so it is low during the ISSUE cycle
          rom_n_cs_s    = 1'b0;
          rom_n_rd_s    = 1'b0;
          rom_address_s = addr_s;
          wait_s        = 4'd0;
          state_s       = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        wait_s  = 4'd0;
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (rom_rdata_en) begin
          if (owner_r == OWN_B) begin
            b_rdata_s    = rom_rdata;
            b_rdata_en_s = 1'b1;
          end else begin
            a_rdata_s    = rom_rdata;
            a_rdata_en_s = 1'b1;
          end
          state_s = ST_IDLE;
        end else if (wait_r == WAIT_LAST_C) begin
          if (owner_r == OWN_B) begin
            b_rdata_s    = TIMEOUT_DATA;
            b_rdata_en_s = 1'b1;
          end else begin
            a_rdata_s    = TIMEOUT_DATA;
            a_rdata_en_s = 1'b1;
          end
          timeout_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          wait_s = wait_r + 4'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Starvation counter: counts every cycle B is left waiting, saturating
    if (!b_req || grant_b_s) begin
      starve_s = 8'd0;
    end else if (starve_r != 8'hFF) begin
      starve_s = starve_r + 8'd1;
    end else begin
      starve_s = starve_r;
    end
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      owner_r     <= OWN_A;
      addr_r      <= 14'd0;
      starve_r    <= 8'd0;
      wait_r      <= 4'd0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= 8'h00;
      b_rdata     <= 8'h00;
      a_rdata_en  <= 1'b0;
      b_rdata_en  <= 1'b0;
      rom_n_cs    <= 1'b1;
      rom_n_rd    <= 1'b1;
      rom_address <= 14'd0;
      timeout     <= 1'b0;
    end else begin
      state_r     <= state_s;
      owner_r     <= owner_s;
      addr_r      <= addr_s;
      starve_r    <= starve_s;
      wait_r      <= wait_s;
      a_ack       <= a_ack_s;
      b_ack       <= b_ack_s;
      a_rdata     <= a_rdata_s;
      b_rdata     <= b_rdata_s;
      a_rdata_en  <= a_rdata_en_s;
      b_rdata_en  <= b_rdata_en_s;
      rom_n_cs    <= rom_n_cs_s;
      rom_n_rd    <= rom_n_rd_s;
      rom_address <= rom_address_s;
      timeout     <= timeout_s;
    end
  end

endmodule
